// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-lights controller and its helpers.
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    HOLD,
    GO,
    FAULT
  } ctrl_state_t;

  // Lights FSM positions 0..8.
  localparam int unsigned LIGHT_STEPS = 9;

  // Fibonacci taps for x^7 + x^6 + 1 (bits 6 and 5 of the shift register).
  localparam logic [31:0] LFSR7_TAPS = 32'h0000_0060;

endpackage

// File: rtl/f1_start_ctrl_if.sv
// Trigger/button inputs and lights-FSM step/reaction outputs of the start controller.
interface f1_start_ctrl_if #(
  parameter int unsigned RT_W = 16
);

  logic            trigger;
  logic            react;
  logic            light_en;
  logic [3:0]      step_cnt;
  logic            busy;
  logic [RT_W-1:0] react_time;
  logic            react_valid;
  logic            jump_start;

  // master: the controller; slave: the integrating top (or bench).
  modport master (
    input  trigger, react,
    output light_en, step_cnt, busy, react_time, react_valid, jump_start
  );

  modport slave (
    output trigger, react,
    input  light_en, step_cnt, busy, react_time, react_valid, jump_start
  );

endinterface

// File: rtl/lfsr_gen.sv
// Free-running Fibonacci LFSR, seeded to 1 on reset; never reaches the all-zero state.
module lfsr_gen #(
  parameter int unsigned     WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS = {2'b11, {(WIDTH-2){1'b0}}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= WIDTH'(1);
    end else if (enable) begin
      q_q <= {q_q[WIDTH-2:0], ^(q_q & TAPS)};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/f1_start_ctrl.sv
// Start-lights sequencer: steps lamps 1..8, holds a pseudo-random delay, signals lights-out,
// then times the driver's reaction and unwinds the lights FSM on a jump start.
module f1_start_ctrl
  import f1_pkg::*;
#(
  parameter int unsigned TICK_DIV = 48,
  parameter int unsigned LFSR_W   = 7,
  parameter int unsigned RT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  f1_start_ctrl_if.master        bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]    LAST_STEP = 4'(LIGHT_STEPS - 1);

  ctrl_state_t     state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            hold_entry_q, hold_entry_d;
  logic [3:0]      step_q, step_d;
  logic [LFSR_W-1:0] delay_q, delay_d;
  logic [RT_W-1:0] rt_q, rt_d;
  logic [RT_W-1:0] react_time_q, react_time_d;
  logic            react_valid_q, react_valid_d;
  logic            jump_q, jump_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic            tick;
  logic            light_en;

  lfsr_gen #(
    .WIDTH (LFSR_W),
    .TAPS  (LFSR7_TAPS[LFSR_W-1:0])
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .enable (1'b1),
    .q      (lfsr_q)
  );

  assign tick = (presc_q == TICK_MAX);

  always_comb begin
    state_d       = state_q;
    presc_d       = '0;
    hold_entry_d  = 1'b0;
    delay_d       = delay_q;
    rt_d          = rt_q;
    react_time_d  = react_time_q;
    react_valid_d = 1'b0;
    jump_d        = 1'b0;
    light_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.trigger) state_d = ARM;
      end
      ARM: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        // A button press outranks a coincident tick so no lamp lights on a jump.
        if (bus.react) begin
          state_d = FAULT;
          jump_d  = 1'b1;
        end else if (tick) begin
          light_en = 1'b1;
          if (step_q == 4'd7) begin
            state_d      = HOLD;
            delay_d      = lfsr_q;
            hold_entry_d = 1'b1;
          end
        end
      end
      HOLD: begin
        // The first HOLD cycle only latches the delay; the prescaler restarts after it.
        presc_d = (hold_entry_q || tick) ? '0 : presc_q + PW'(1);
        if (bus.react) begin
          state_d = FAULT;
          jump_d  = 1'b1;
        end else if (tick) begin
          delay_d = delay_q - LFSR_W'(1);
          if (delay_q == LFSR_W'(1)) begin
            light_en = 1'b1;
            state_d  = GO;
            rt_d     = '0;
          end
        end
      end
      GO: begin
        if (rt_q != '1) rt_d = rt_q + RT_W'(1);
        if (bus.react) begin
          react_time_d  = rt_q;
          react_valid_d = 1'b1;
          state_d       = IDLE;
        end
      end
      FAULT: begin
        // Keep stepping the lights FSM until it wraps back to all-off.
        if (step_q != 4'd0) light_en = 1'b1;
        else                state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    step_d = step_q;
    if (light_en) step_d = (step_q == LAST_STEP) ? 4'd0 : step_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      presc_q       <= '0;
      hold_entry_q  <= 1'b0;
      step_q        <= 4'd0;
      delay_q       <= '0;
      rt_q          <= '0;
      react_time_q  <= '0;
      react_valid_q <= 1'b0;
      jump_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      hold_entry_q  <= hold_entry_d;
      step_q        <= step_d;
      delay_q       <= delay_d;
      rt_q          <= rt_d;
      react_time_q  <= react_time_d;
      react_valid_q <= react_valid_d;
      jump_q        <= jump_d;
    end
  end

  assign bus.light_en    = light_en;
  assign bus.step_cnt    = step_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.react_time  = react_time_q;
  assign bus.react_valid = react_valid_q;
  assign bus.jump_start  = jump_q;

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Scoreboard bench for f1_start_ctrl with TICK_DIV=4, LFSR_W=7, RT_W=16.
module tb_f1_start_ctrl;

  logic clk;
  logic rst;

  f1_start_ctrl_if #(.RT_W(16)) bus ();

  f1_start_ctrl #(
    .TICK_DIV (4),
    .LFSR_W   (7),
    .RT_W     (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t0;
  int d_exp;
  logic [6:0] lfsr_m;

  int          exp_q[$];
  int          got_q[$];
  int          js_q[$];
  logic [15:0] rv_q[$];
  logic [15:0] rt_exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] lfsr_next(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  // Reference LFSR: seed 1, shifts every cycle out of reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) lfsr_m <= 7'd1;
    else      lfsr_m <= lfsr_next(lfsr_m);
  end

  // Advance one cycle and log the observable events of the cycle just entered.
  task automatic step();
    @(negedge clk);
    if (bus.light_en)    got_q.push_back(cyc);
    if (bus.jump_start)  js_q.push_back(cyc);
    if (bus.react_valid) rv_q.push_back(bus.react_time);
  endtask

  task automatic wait_pulses(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) step();
  endtask

  task automatic clear_logs();
    exp_q.delete(); got_q.delete(); js_q.delete(); rv_q.delete(); rt_exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.trigger = 1'b0;
    bus.react   = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.light_en !== 1'b0) $display("FAIL reset_light_en: got %0b want 0", bus.light_en); else n_pass++;
    n_checks++; if (bus.step_cnt !== 4'd0) $display("FAIL reset_step_cnt: got %0d want 0", bus.step_cnt); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.react_time !== 16'd0) $display("FAIL reset_react_time: got %0d want 0", bus.react_time); else n_pass++;
    n_checks++; if (bus.react_valid !== 1'b0) $display("FAIL reset_react_valid: got %0b want 0", bus.react_valid); else n_pass++;
    n_checks++; if (bus.jump_start !== 1'b0) $display("FAIL reset_jump_start: got %0b want 0", bus.jump_start); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_lights();
    int busy_low;
    int e, g;
    clear_logs();
    step();
    t0 = cyc;
    bus.trigger = 1'b1;
    d_exp = int'(lfsr_m);
    for (int i = 0; i < 32; i++) d_exp = int'(lfsr_next(7'(d_exp)));
    for (int k = 1; k <= 8; k++) exp_q.push_back(t0 + 4 * k);
    busy_low = 0;
    step();
    bus.trigger = 1'b0;
    if (!bus.busy) busy_low++;
    for (int i = 0; i < 40 && got_q.size() < 8; i++) begin
      step();
      if (!bus.busy) busy_low++;
    end
    step();
    if (!bus.busy) busy_low++;
    n_checks++; if (bus.step_cnt !== 4'd8) $display("FAIL lights_step_cnt: got %0d want 8", bus.step_cnt); else n_pass++;
    n_checks++; if (busy_low != 0) $display("FAIL lights_busy: got %0d idle cycles want 0", busy_low); else n_pass++;
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL lights_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++; if (g != e) $display("FAIL lights_pulse_cycle: got %0d want %0d", g, e); else n_pass++;
    end
  endtask

  task automatic test_normal_run();
    int e, g;
    exp_q.delete(); got_q.delete(); rv_q.delete();
    exp_q.push_back(t0 + 33 + 4 * d_exp);
    wait_pulses(1, 600);
    n_checks++; if (got_q.size() != 1) $display("FAIL lightsout_seen: got %0d pulses want 1", got_q.size()); else n_pass++;
    if (got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++; if (g != e) $display("FAIL lightsout_cycle: got %0d want %0d", g, e); else n_pass++;
    end
    repeat (11) step();
    bus.react = 1'b1;
    rt_exp_q.push_back(16'd10);
    step();
    bus.react = 1'b0;
    n_checks++; if (rv_q.size() != 1) $display("FAIL run_react_valid: got %0d pulses want 1", rv_q.size()); else n_pass++;
    if (rv_q.size() > 0 && rt_exp_q.size() > 0) begin
      n_checks++;
      if (rv_q[0] !== rt_exp_q[0]) $display("FAIL run_react_time: got %0d want %0d", rv_q[0], rt_exp_q[0]);
      else n_pass++;
    end
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL run_busy: got %0b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_jump_arm();
    int e, g;
    clear_logs();
    step();
    t0 = cyc;
    bus.trigger = 1'b1;
    for (int k = 1; k <= 3; k++) exp_q.push_back(t0 + 4 * k);
    step();
    bus.trigger = 1'b0;
    wait_pulses(3, 20);
    repeat (2) step();
    bus.react = 1'b1;
    for (int k = 15; k <= 20; k++) exp_q.push_back(t0 + k);
    step();
    bus.react = 1'b0;
    repeat (15) step();
    n_checks++; if (js_q.size() != 1) $display("FAIL arm_jump_count: got %0d want 1", js_q.size()); else n_pass++;
    if (js_q.size() > 0) begin
      n_checks++; if (js_q[0] != t0 + 15) $display("FAIL arm_jump_cycle: got %0d want %0d", js_q[0], t0 + 15); else n_pass++;
    end
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL arm_pulse_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++; if (g != e) $display("FAIL arm_pulse_cycle: got %0d want %0d", g, e); else n_pass++;
    end
    n_checks++; if (bus.step_cnt !== 4'd0) $display("FAIL arm_step_cnt: got %0d want 0", bus.step_cnt); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL arm_busy: got %0b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.react_time !== 16'd10) $display("FAIL arm_react_time: got %0d want 10", bus.react_time); else n_pass++;
  endtask

  task automatic test_jump_hold();
    int e, g;
    clear_logs();
    step();
    t0 = cyc;
    bus.trigger = 1'b1;
    for (int k = 1; k <= 8; k++) exp_q.push_back(t0 + 4 * k);
    step();
    bus.trigger = 1'b0;
    wait_pulses(8, 40);
    repeat (2) step();
    bus.react = 1'b1;
    exp_q.push_back(t0 + 35);
    step();
    bus.react   = 1'b0;
    bus.trigger = 1'b1;
    repeat (2) step();
    bus.trigger = 1'b0;
    repeat (20) step();
    n_checks++; if (js_q.size() != 1) $display("FAIL hold_jump_count: got %0d want 1", js_q.size()); else n_pass++;
    if (js_q.size() > 0) begin
      n_checks++; if (js_q[0] != t0 + 35) $display("FAIL hold_jump_cycle: got %0d want %0d", js_q[0], t0 + 35); else n_pass++;
    end
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL hold_pulse_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++; if (g != e) $display("FAIL hold_pulse_cycle: got %0d want %0d", g, e); else n_pass++;
    end
    n_checks++; if (bus.step_cnt !== 4'd0) $display("FAIL hold_step_cnt: got %0d want 0", bus.step_cnt); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL hold_trigger_dropped: busy %0b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_saturation();
    clear_logs();
    step();
    bus.trigger = 1'b1;
    step();
    bus.trigger = 1'b0;
    wait_pulses(9, 700);
    n_checks++; if (got_q.size() != 9) $display("FAIL sat_pulses: got %0d want 9", got_q.size()); else n_pass++;
    repeat (70000) step();
    bus.react = 1'b1;
    rt_exp_q.push_back(16'hFFFF);
    step();
    bus.react = 1'b0;
    n_checks++; if (rv_q.size() != 1) $display("FAIL sat_react_valid: got %0d pulses want 1", rv_q.size()); else n_pass++;
    if (rv_q.size() > 0 && rt_exp_q.size() > 0) begin
      n_checks++;
      if (rv_q[0] !== rt_exp_q[0]) $display("FAIL sat_react_time: got %0h want %0h", rv_q[0], rt_exp_q[0]);
      else n_pass++;
    end
  endtask

  task automatic test_corners();
    clear_logs();
    step();
    bus.trigger = 1'b1;
    step();
    bus.trigger = 1'b0;
    wait_pulses(8, 40);
    repeat (2) step();
    rst = 1'b0;
    #1;
    n_checks++; if (bus.light_en !== 1'b0) $display("FAIL rst_light_en: got %0b want 0", bus.light_en); else n_pass++;
    n_checks++; if (bus.step_cnt !== 4'd0) $display("FAIL rst_step_cnt: got %0d want 0", bus.step_cnt); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.react_time !== 16'd0) $display("FAIL rst_react_time: got %0d want 0", bus.react_time); else n_pass++;
    step();
    rst = 1'b1;
    got_q.delete();
    repeat (40) step();
    n_checks++; if (got_q.size() != 0) $display("FAIL rst_no_pulses: got %0d want 0", got_q.size()); else n_pass++;

    clear_logs();
    step();
    t0 = cyc;
    bus.trigger = 1'b1;
    bus.react   = 1'b1;
    exp_q.push_back(t0 + 4);
    step();
    bus.trigger = 1'b0;
    bus.react   = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL both_busy: got %0b want 1", bus.busy); else n_pass++;
    wait_pulses(1, 10);
    n_checks++; if (js_q.size() != 0) $display("FAIL both_jump_start: got %0d pulses want 0", js_q.size()); else n_pass++;
    n_checks++;
    if (got_q.size() == 0 || got_q[0] != exp_q[0]) begin
      $display("FAIL both_first_pulse: got %0d want %0d", (got_q.size() > 0) ? got_q[0] : -1, exp_q[0]);
    end else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    bus.trigger = 1'b0;
    bus.react   = 1'b0;
    test_reset();
    test_lights();
    test_normal_run();
    test_jump_arm();
    test_jump_hold();
    test_saturation();
    test_corners();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
